// File: rtl/all_pkgs.sv
// Shared constants, funct3 width codes and state types for the memory access stage.
package all_pkgs;
   localparam int WIDTH = 32;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
   typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2} size_t;

   // Stores only define SB/SH/SW, so BU/HU codes fall back to word for them.
   function automatic size_t access_size(input logic is_store, input logic [2:0] f3);
      size_t s;
      s = SZ_W;
      if (is_store) begin
         case (f3)
            F3_B:    s = SZ_B;
            F3_H:    s = SZ_H;
            F3_W:    s = SZ_W;
            default: s = SZ_W;
         endcase
      end else begin
         case (f3)
            F3_B, F3_BU: s = SZ_B;
            F3_H, F3_HU: s = SZ_H;
            F3_W:        s = SZ_W;
            default:     s = SZ_W;
         endcase
      end
      return s;
   endfunction
endpackage

// File: rtl/load_align.sv
// Extracts the addressed byte/half from a read word and sign- or zero-extends it.
module load_align
   import all_pkgs::*;
(
   input  logic [WIDTH-1:0] rdata,
   input  logic [1:0]       offset,
   input  logic [2:0]       funct3,
   output logic [WIDTH-1:0] result
);
   logic [WIDTH-1:0] shifted;

   assign shifted = rdata >> {offset, 3'b000};

   always_comb begin
      result = rdata;
      case (funct3)
         F3_B:    result = {{(WIDTH-8){shifted[7]}}, shifted[7:0]};
         F3_BU:   result = {{(WIDTH-8){1'b0}}, shifted[7:0]};
         F3_H:    result = {{(WIDTH-16){shifted[15]}}, shifted[15:0]};
         F3_HU:   result = {{(WIDTH-16){1'b0}}, shifted[15:0]};
         default: result = rdata;
      endcase
   end
endmodule

// File: rtl/mem_access_stage.sv
// Memory access pipeline stage: issues data-memory requests, aligns load data, drives writeback.
// Optional: define MISALIGN_TRAP_EN to trap misaligned accesses instead of forcing alignment.
module mem_access_stage
   import all_pkgs::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             ex_valid,
   input  logic [WIDTH-1:0] alu_result,
   input  logic [WIDTH-1:0] store_data,
   input  logic [6:0]       opcode,
   input  logic [2:0]       funct3,
   input  logic [4:0]       rd,
   output logic             stall,
   output logic             dmem_req,
   output logic             dmem_we,
   output logic [WIDTH-1:0] dmem_addr,
   output logic [WIDTH-1:0] dmem_wdata,
   output logic [3:0]       dmem_be,
   input  logic             dmem_ack,
   input  logic [WIDTH-1:0] dmem_rdata,
   output logic             wb_valid,
   output logic             wb_we,
   output logic [4:0]       wb_rd,
   output logic [WIDTH-1:0] wb_data,
   output logic             misalign_trap
);
   state_t           state, state_nxt;
   size_t            size;
   logic             accept, is_load, is_store, is_mem, trap_take, mem_go;
   logic [1:0]       off;
   logic [3:0]       be_nxt;
   logic [WIDTH-1:0] wdata_nxt;
   logic [WIDTH-1:0] load_res;
   logic [4:0]       rd_q;
   logic [2:0]       f3_q;
   logic [1:0]       off_q;
   logic             load_q;

   assign stall    = (state == BUSY);
   assign accept   = ex_valid && (state == IDLE);
   assign is_load  = (opcode == OP_LOAD);
   assign is_store = (opcode == OP_STORE);
   assign is_mem   = is_load || is_store;
   assign size     = access_size(is_store, funct3);

`ifdef MISALIGN_TRAP_EN
   logic misaligned;
   assign misaligned = ((size == SZ_H) && alu_result[0]) ||
                       ((size == SZ_W) && (alu_result[1:0] != 2'b00));
   assign trap_take  = accept && is_mem && misaligned;
`else
   assign trap_take  = 1'b0;
`endif

   assign mem_go = accept && is_mem && !trap_take;

   // Offset drops the low bits a half/word cannot use, so untrapped accesses stay aligned.
   always_comb begin
      off       = 2'b00;
      be_nxt    = 4'b1111;
      wdata_nxt = store_data;
      case (size)
         SZ_B: begin
            off       = alu_result[1:0];
            be_nxt    = 4'b0001 << off;
            wdata_nxt = {4{store_data[7:0]}};
         end
         SZ_H: begin
            off       = {alu_result[1], 1'b0};
            be_nxt    = 4'b0011 << off;
            wdata_nxt = {2{store_data[15:0]}};
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (mem_go) state_nxt = BUSY;
         BUSY:    if (dmem_ack) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   load_align u_load_align (
      .rdata  (dmem_rdata),
      .offset (off_q),
      .funct3 (f3_q),
      .result (load_res)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         dmem_req      <= 1'b0;
         dmem_we       <= 1'b0;
         dmem_be       <= 4'b0000;
         dmem_addr     <= '0;
         dmem_wdata    <= '0;
         wb_valid      <= 1'b0;
         wb_we         <= 1'b0;
         wb_rd         <= '0;
         wb_data       <= '0;
         misalign_trap <= 1'b0;
         rd_q          <= '0;
         f3_q          <= '0;
         off_q         <= '0;
         load_q        <= 1'b0;
      end else begin
         wb_valid      <= 1'b0;
         wb_we         <= 1'b0;
         misalign_trap <= 1'b0;
         if (state == BUSY) begin
            if (dmem_ack) begin
               dmem_req <= 1'b0;
               wb_valid <= 1'b1;
               wb_we    <= load_q && (rd_q != 5'd0);
               wb_rd    <= rd_q;
               wb_data  <= load_res;
            end
         end else if (mem_go) begin
            dmem_req   <= 1'b1;
            dmem_we    <= is_store;
            dmem_addr  <= {alu_result[WIDTH-1:2], 2'b00};
            dmem_be    <= be_nxt;
            dmem_wdata <= wdata_nxt;
            rd_q       <= rd;
            f3_q       <= funct3;
            off_q      <= off;
            load_q     <= is_load;
         end else if (accept) begin
            // Non-memory ops and trapped accesses retire straight to writeback.
            wb_valid      <= 1'b1;
            wb_we         <= !trap_take && (rd != 5'd0);
            wb_rd         <= rd;
            wb_data       <= alu_result;
            misalign_trap <= trap_take;
         end
      end
   end
endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios plus random ops vs a reference model.
module tb_mem_access_stage;
   import all_pkgs::*;

`ifdef MISALIGN_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   logic        clk, rst, ex_valid;
   logic [31:0] alu_result, store_data;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [4:0]  rd;
   logic        stall, dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic [3:0]  dmem_be;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;
   logic        wb_valid, wb_we;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        misalign_trap;

   int errors = 0;
   int checks = 0;

   mem_access_stage dut (
      .clk(clk), .rst(rst), .ex_valid(ex_valid), .alu_result(alu_result),
      .store_data(store_data), .opcode(opcode), .funct3(funct3), .rd(rd),
      .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
      .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd),
      .wb_data(wb_data), .misalign_trap(misalign_trap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          mem;
      bit          load;
      bit          trap;
      int          size;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] ldata;
      logic        wb_we;
   } exp_t;

   // Reference: access size in bytes, byte offset, masks and replication by arithmetic.
   function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] r,
                                  input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdat);
      exp_t e;
      int off;
      logic [31:0] mask;
      e.load = (op == 7'b0000011);
      e.mem  = e.load || (op == 7'b0100011);
      if (e.load) e.size = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
      else        e.size = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
      e.trap = TRAP_EN && e.mem && ((a % e.size) != 0);
      off = int'(a % 4);
      off = off - (off % e.size);
      e.be = 4'(((1 << e.size) - 1) << off);
      e.addr = a - (a % 4);
      mask = (e.size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * e.size)) - 32'd1);
      e.wdata = (e.size == 1) ? (sd & 32'hFF) * 32'h0101_0101 :
                (e.size == 2) ? (sd & 32'hFFFF) * 32'h0001_0001 : sd;
      e.ldata = (rdat >> (8 * off)) & mask;
      if (e.size < 4 && f3[2] == 1'b0 && e.ldata[8 * e.size - 1]) e.ldata = e.ldata | ~mask;
      e.wb_we = (r != 5'd0) && !e.trap && !(e.mem && !e.load);
      return e;
   endfunction

   // Observations captured by run_op
   logic        o_stall_in, o_wb_valid, o_wb_we, o_trap, o_we, o_stable, o_stall_after, o_req_after;
   logic [4:0]  o_wb_rd;
   logic [31:0] o_wb_data, o_addr, o_wdata;
   logic [3:0]  o_be;
   int          o_req_cycles, o_stall_cycles, o_busy_wb;

   task automatic run_op(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] r,
                         input logic [31:0] a, input logic [31:0] sd, input int delay,
                         input logic [31:0] rdat);
      int n;
      @(negedge clk);
      ex_valid = 1'b1; opcode = op; funct3 = f3; rd = r; alu_result = a; store_data = sd;
      o_stall_in = stall;
      @(posedge clk);
      @(negedge clk);
      ex_valid = 1'b0;
      n = 0; o_stall_cycles = 0; o_busy_wb = 0; o_stable = 1'b1;
      o_addr = 'x; o_be = 'x; o_we = 'x; o_wdata = 'x;
      while (dmem_req === 1'b1 && n < 64) begin
         n++;
         if (stall === 1'b1) o_stall_cycles++;
         if (wb_valid !== 1'b0) o_busy_wb++;
         if (n == 1) begin
            o_addr = dmem_addr; o_be = dmem_be; o_we = dmem_we; o_wdata = dmem_wdata;
         end else if (dmem_addr !== o_addr || dmem_be !== o_be || dmem_we !== o_we ||
                      dmem_wdata !== o_wdata) begin
            o_stable = 1'b0;
         end
         // Junk upstream traffic while busy must be ignored.
         ex_valid = 1'b1; opcode = 7'b0110011; alu_result = $urandom; rd = 5'd9;
         if (n == delay) begin dmem_ack = 1'b1; dmem_rdata = rdat; end
         @(posedge clk);
         @(negedge clk);
         dmem_ack = 1'b0;
         dmem_rdata = $urandom;
      end
      ex_valid = 1'b0;
      o_req_cycles = n;
      o_wb_valid = wb_valid; o_wb_we = wb_we; o_wb_rd = wb_rd; o_wb_data = wb_data;
      o_trap = misalign_trap; o_stall_after = stall; o_req_after = dmem_req;
   endtask

   task automatic test_reset();
      rst = 1'b1; ex_valid = 1'b1; opcode = 7'b0000011; funct3 = 3'd2; rd = 5'd1;
      alu_result = 32'h100; store_data = 0; dmem_ack = 1'b0; dmem_rdata = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({stall, dmem_req, dmem_we, dmem_be, wb_valid, wb_we, misalign_trap} !== 10'd0) begin
         errors++;
         $display("FAIL reset_outputs got stall=%b req=%b we=%b be=%b wbv=%b wbwe=%b trap=%b exp all 0",
                  stall, dmem_req, dmem_we, dmem_be, wb_valid, wb_we, misalign_trap);
      end
      rst = 1'b0; ex_valid = 1'b0;
   endtask

   task automatic test_lw();
      run_op(OP_LOAD, F3_W, 5'd1, 32'h100, 32'h0, 4, 32'hDEADBEEF);
      checks++; if (o_addr !== 32'h100) begin errors++; $display("FAIL lw_addr got=%h exp=%h", o_addr, 32'h100); end
      checks++; if (o_be !== 4'hF) begin errors++; $display("FAIL lw_be got=%b exp=1111", o_be); end
      checks++; if (o_req_cycles != 4) begin errors++; $display("FAIL lw_req_cycles got=%0d exp=4", o_req_cycles); end
      checks++; if (o_stall_cycles != 4) begin errors++; $display("FAIL lw_stall_cycles got=%0d exp=4", o_stall_cycles); end
      checks++; if (o_wb_valid !== 1'b1 || o_wb_data !== 32'hDEADBEEF || o_wb_rd !== 5'd1 || o_wb_we !== 1'b1) begin
         errors++; $display("FAIL lw_wb got v=%b d=%h rd=%0d we=%b exp v=1 d=deadbeef rd=1 we=1", o_wb_valid, o_wb_data, o_wb_rd, o_wb_we);
      end
      checks++; if (o_stall_after !== 1'b0 || o_req_after !== 1'b0) begin
         errors++; $display("FAIL lw_release got stall=%b req=%b exp 0 0", o_stall_after, o_req_after);
      end
   endtask

   task automatic test_lb();
      run_op(OP_LOAD, F3_B, 5'd7, 32'h103, 32'h0, 1, 32'h80112233);
      checks++; if (o_be !== 4'b1000) begin errors++; $display("FAIL lb_be got=%b exp=1000", o_be); end
      checks++; if (o_wb_data !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_data got=%h exp=ffffff80", o_wb_data); end
      run_op(OP_LOAD, F3_BU, 5'd7, 32'h103, 32'h0, 2, 32'h80112233);
      checks++; if (o_wb_data !== 32'h00000080) begin errors++; $display("FAIL lbu_data got=%h exp=00000080", o_wb_data); end
   endtask

   task automatic test_sh();
      run_op(OP_STORE, F3_H, 5'd4, 32'h202, 32'h0000ABCD, 2, 32'h0);
      checks++; if (o_be !== 4'b1100) begin errors++; $display("FAIL sh_be got=%b exp=1100", o_be); end
      checks++; if (o_wdata !== 32'hABCDABCD || o_we !== 1'b1 || o_addr !== 32'h200) begin
         errors++; $display("FAIL sh_req got wdata=%h we=%b addr=%h exp abcdabcd 1 200", o_wdata, o_we, o_addr);
      end
      checks++; if (o_wb_valid !== 1'b1 || o_wb_we !== 1'b0) begin
         errors++; $display("FAIL sh_wb got v=%b we=%b exp v=1 we=0", o_wb_valid, o_wb_we);
      end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      ex_valid = 1'b1; opcode = 7'b0110011; funct3 = 3'd0; alu_result = 32'h55; rd = 5'd5;
      @(posedge clk); @(negedge clk);
      checks++; if (wb_valid !== 1'b1 || wb_data !== 32'h55 || wb_rd !== 5'd5 || wb_we !== 1'b1) begin
         errors++; $display("FAIL b2b_first got v=%b d=%h rd=%0d we=%b exp 1 55 5 1", wb_valid, wb_data, wb_rd, wb_we);
      end
      alu_result = 32'h66; rd = 5'd0;
      @(posedge clk); @(negedge clk);
      checks++; if (wb_valid !== 1'b1 || wb_data !== 32'h66 || wb_rd !== 5'd0 || wb_we !== 1'b0) begin
         errors++; $display("FAIL b2b_second got v=%b d=%h rd=%0d we=%b exp 1 66 0 0", wb_valid, wb_data, wb_rd, wb_we);
      end
      ex_valid = 1'b0;
      @(posedge clk); @(negedge clk);
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL b2b_pulse got wb_valid=%b exp 0", wb_valid); end
   endtask

   task automatic test_misalign();
      run_op(OP_LOAD, F3_W, 5'd3, 32'h102, 32'h0, 2, 32'h12345678);
`ifdef MISALIGN_TRAP_EN
      checks++; if (o_trap !== 1'b1 || o_req_cycles != 0) begin
         errors++; $display("FAIL mis_trap got trap=%b req_cycles=%0d exp 1 0", o_trap, o_req_cycles);
      end
      checks++; if (o_wb_valid !== 1'b1 || o_wb_we !== 1'b0 || o_wb_data !== 32'h102) begin
         errors++; $display("FAIL mis_wb got v=%b we=%b d=%h exp 1 0 102", o_wb_valid, o_wb_we, o_wb_data);
      end
`else
      checks++; if (o_addr !== 32'h100 || o_be !== 4'hF || o_trap !== 1'b0) begin
         errors++; $display("FAIL mis_forced got addr=%h be=%b trap=%b exp 100 1111 0", o_addr, o_be, o_trap);
      end
      checks++; if (o_wb_valid !== 1'b1 || o_wb_data !== 32'h12345678) begin
         errors++; $display("FAIL mis_wb got v=%b d=%h exp 1 12345678", o_wb_valid, o_wb_data);
      end
`endif
   endtask

   task automatic test_ack_idle();
      @(negedge clk);
      dmem_ack = 1'b1; dmem_rdata = 32'hCAFEF00D;
      repeat (2) begin
         @(posedge clk); @(negedge clk);
         checks++; if (stall !== 1'b0 || wb_valid !== 1'b0 || dmem_req !== 1'b0) begin
            errors++; $display("FAIL ack_idle got stall=%b wbv=%b req=%b exp 0 0 0", stall, wb_valid, dmem_req);
         end
      end
      dmem_ack = 1'b0;
   endtask

   task automatic test_rst_mid();
      int wbs;
      @(negedge clk);
      ex_valid = 1'b1; opcode = OP_LOAD; funct3 = F3_W; rd = 5'd8; alu_result = 32'h300;
      @(posedge clk); @(negedge clk);
      ex_valid = 1'b0;
      checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL rstmid_busy got req=%b exp 1", dmem_req); end
      rst = 1'b1;
      @(posedge clk); @(negedge clk);
      rst = 1'b0;
      wbs = (wb_valid === 1'b1) ? 1 : 0;
      checks++; if (dmem_req !== 1'b0 || stall !== 1'b0) begin
         errors++; $display("FAIL rstmid_abandon got req=%b stall=%b exp 0 0", dmem_req, stall);
      end
      @(posedge clk); @(negedge clk);
      if (wb_valid === 1'b1) wbs++;
      dmem_ack = 1'b1; dmem_rdata = 32'h11111111;
      @(posedge clk); @(negedge clk);
      dmem_ack = 1'b0;
      if (wb_valid === 1'b1) wbs++;
      @(posedge clk); @(negedge clk);
      if (wb_valid === 1'b1) wbs++;
      checks++; if (wbs != 0 || dmem_req !== 1'b0) begin
         errors++; $display("FAIL rstmid_nowb got wb_pulses=%0d req=%b exp 0 0", wbs, dmem_req);
      end
      run_op(OP_LOAD, F3_H, 5'd2, 32'h302, 32'h0, 3, 32'h8001_7FFF);
      checks++; if (o_stall_in !== 1'b0 || o_wb_valid !== 1'b1 || o_wb_data !== 32'hFFFF8001 || o_be !== 4'b1100) begin
         errors++; $display("FAIL rstmid_next got stall=%b v=%b d=%h be=%b exp 0 1 ffff8001 1100",
                            o_stall_in, o_wb_valid, o_wb_data, o_be);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 60; i++) begin
         logic [6:0] op; logic [2:0] f3; logic [4:0] r; logic [31:0] a, sd, rdat; int d; exp_t e;
         case ($urandom_range(0, 3))
            0: op = 7'b0000011;
            1: op = 7'b0100011;
            2: op = 7'b0110011;
            default: op = 7'b0010011;
         endcase
         f3 = 3'($urandom_range(0, 7)); r = 5'($urandom_range(0, 31));
         a = 32'h1000 + $urandom_range(0, 255); sd = $urandom; rdat = $urandom;
         d = $urandom_range(1, 4);
         e = model(op, f3, r, a, sd, rdat);
         run_op(op, f3, r, a, sd, d, rdat);
         checks++; if (o_stall_in !== 1'b0) begin errors++; $display("FAIL rnd%0d_accept got stall=%b exp 0", i, o_stall_in); end
         checks++; if (o_wb_valid !== 1'b1 || o_wb_we !== e.wb_we || o_wb_rd !== r || o_trap !== e.trap) begin
            errors++; $display("FAIL rnd%0d_wb got v=%b we=%b rd=%0d trap=%b exp 1 %b %0d %b", i, o_wb_valid, o_wb_we, o_wb_rd, o_trap, e.wb_we, r, e.trap);
         end
         if (e.mem && !e.trap) begin
            checks++; if (o_req_cycles != d || o_stall_cycles != d || !o_stable || o_busy_wb != 0 || o_req_after !== 1'b0) begin
               errors++; $display("FAIL rnd%0d_hs got req=%0d stall=%0d stable=%b busywb=%0d after=%b exp %0d %0d 1 0 0", i, o_req_cycles, o_stall_cycles, o_stable, o_busy_wb, o_req_after, d, d);
            end
            checks++; if (o_addr !== e.addr || o_be !== e.be || o_we !== !e.load) begin
               errors++; $display("FAIL rnd%0d_req got addr=%h be=%b we=%b exp %h %b %b", i, o_addr, o_be, o_we, e.addr, e.be, !e.load);
            end
            if (e.load) begin
               checks++; if (o_wb_data !== e.ldata) begin errors++; $display("FAIL rnd%0d_ldata got=%h exp=%h f3=%0d a=%h", i, o_wb_data, e.ldata, f3, a); end
            end else begin
               checks++; if (o_wdata !== e.wdata) begin errors++; $display("FAIL rnd%0d_wdata got=%h exp=%h", i, o_wdata, e.wdata); end
            end
         end else begin
            checks++; if (o_req_cycles != 0 || o_wb_data !== a) begin
               errors++; $display("FAIL rnd%0d_direct got req=%0d d=%h exp 0 %h", i, o_req_cycles, o_wb_data, a);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_lw();
      test_lb();
      test_sh();
      test_back_to_back();
      test_misalign();
      test_ack_idle();
      test_rst_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 The block SHALL take WIDTH (=32) from all_pkgs; it has no module parameters.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 ex_valid  input  1  execute-stage result valid this cycle.
REQ-005 alu_result  input  WIDTH  effective address for load/store; result for other ops.
REQ-006 store_data  input  WIDTH  rs2 value for stores.
REQ-007 opcode / funct3 / rd  input  7 / 3 / 5  instruction fields carried from execute.
REQ-008 stall  output  1  high while busy; upstream holds its inputs and ex_valid is not accepted.
REQ-009 dmem_req, dmem_we  output  1, 1  request strobe and write enable to data memory.
REQ-010 dmem_addr, dmem_wdata  output  WIDTH each  word-aligned address (bits [1:0]=0) and lane-replicated write data.
REQ-011 dmem_be  output  4  byte enables.
REQ-012 dmem_ack, dmem_rdata  input  1, WIDTH  memory completion strobe and read word.
REQ-013 wb_valid, wb_we, wb_rd, wb_data  output  1, 1, 5, WIDTH  writeback bundle, valid for one cycle.
REQ-014 misalign_trap  output  1  one-cycle pulse on a misaligned access.

Function
REQ-015 The block SHALL accept an op in cycle T when ex_valid=1 and stall=0.
REQ-016 A non-memory op SHALL produce wb_valid=1, wb_data=alu_result, wb_rd=rd and wb_we=(rd!=0) at T+1.
REQ-017 The FSM SHALL have two states, IDLE and BUSY: IDLE->BUSY on accepting a load/store; BUSY->IDLE in the cycle dmem_ack=1.
REQ-018 dmem_req SHALL be registered, asserted from T+1, and held with stable addr/we/be/wdata through the ack cycle A inclusive; it is 0 at A+1.
REQ-019 stall SHALL equal (state==BUSY); the next op can be accepted at A+1 at the earliest.
REQ-020 Byte enables SHALL be SB/LB/LBU: 1<<addr[1:0]; SH/LH/LHU: 4'b0011<<addr[1:0]; SW/LW: 4'b1111.
REQ-021 For stores, dmem_wdata SHALL replicate the byte/half across all lanes.
REQ-022 Load data SHALL be selected by addr[1:0]: sign-extended for LB/LH and zero-extended for LBU/LHU, with the result registered at A.
REQ-023 A load SHALL produce wb_valid=1 at A+1, with wb_we=(rd!=0), the extended data, and wb_rd=rd.
REQ-024 A store SHALL produce wb_valid=1 with wb_we=0 at A+1.
REQ-025 Unlisted funct3 encodings SHALL be treated as word accesses.
REQ-026 dmem_ack SHALL be ignored in IDLE.
REQ-027 ex_valid SHALL be ignored while stall=1.
REQ-028 Back-to-back non-memory ops SHALL flow at one per cycle with no bubbles.

Reset
REQ-029 While rst=1, the FSM SHALL be in IDLE, and stall, dmem_req, dmem_we, dmem_be, wb_valid, wb_we and misalign_trap SHALL all be 0.
REQ-030 Assertion of rst mid-transaction SHALL abandon the access: dmem_req is 0 from the next edge, and no writeback is produced.

Configuration
REQ-031 With MISALIGN_TRAP_EN defined, a misaligned access (half with addr[0]=1, or word with addr[1:0]!=0) SHALL issue no dmem_req and stay in IDLE; at T+1 it SHALL produce misalign_trap=1, wb_valid=1, wb_we=0 and wb_data=alu_result.
REQ-032 Without MISALIGN_TRAP_EN, misalign_trap SHALL be tied 0, the offending low address bits SHALL be forced to 0, and the access SHALL proceed normally.

Structure
REQ-033 OP_LOAD (7'b0000011), OP_STORE (7'b0100011), the funct3 width codes and the state enum SHALL live in all_pkgs.
REQ-034 Load extraction and extension SHALL be one combinational sub-module, load_align (inputs rdata, offset, funct3; output WIDTH result).

Verification
REQ-035 LW at addr 0x100, with dmem_ack 3 cycles after dmem_req and rdata=0xDEADBEEF -> stall high for exactly those cycles; wb_data=0xDEADBEEF at A+1.
REQ-036 LB at addr 0x103 with rdata=0x80112233 -> be=4'b1000; wb_data=0xFFFFFF80. LBU at the same address -> wb_data=0x00000080.
REQ-037 SH at addr 0x202 with store_data=0x0000ABCD -> be=4'b1100, wdata=0xABCDABCD, dmem_we=1; wb_valid with wb_we=0.
REQ-038 ADD result 0x55 with rd=5, followed next cycle by 0x66 with rd=0 -> wb at consecutive cycles; the second has wb_we=0.
REQ-039 LW at addr 0x102, with and without MISALIGN_TRAP_EN -> trap pulse and no dmem_req; or dmem_addr=0x100 with be=4'b1111.
REQ-040 rst asserted 1 cycle into BUSY, followed by a late ack -> no wb_valid, dmem_req=0, and the next op is accepted normally.
